// File: rtl/md_ring_pkg.sv
// Shared types for the MD ring: force packet layout and the injection phase states.
package md_ring_pkg;

    localparam int NUM_CELLS         = 64;
    localparam int DATA_WIDTH        = 32;
    localparam int PARTICLE_ID_WIDTH = 7;
    localparam int FORCE_DATA_WIDTH  = 3 * DATA_WIDTH + PARTICLE_ID_WIDTH;
    localparam int NODE_ID_WIDTH     = $clog2(NUM_CELLS);

    function automatic int node_id_width();
        return $clog2(NUM_CELLS);
    endfunction

    typedef struct packed {
        logic [NODE_ID_WIDTH-1:0]    dest_id;
        logic [FORCE_DATA_WIDTH-1:0] payload;
    } packet_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } inj_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after ptr.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic                 en,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_idx
);

    localparam int PTR_W = $clog2(N);

    always_comb begin
        logic             found;
        logic [PTR_W-1:0] idx;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = '0;
        for (int k = 0; k < N; k++) begin
            idx = PTR_W'((int'(ptr) + k) % N);
            if (en && !found && req[idx]) begin
                found      = 1'b1;
                gnt[idx]   = 1'b1;
                gnt_idx    = idx;
            end
        end
    end

endmodule

// File: rtl/ring_inject_arbiter.sv
// Shares one ring node's PE injection port among NUM_SRC sources through a
// single-entry output register, gated by a per-phase IDLE/RUN/DRAIN/DONE FSM.
module ring_inject_arbiter
    import md_ring_pkg::*;
#(
    parameter int NUM_CELLS         = 64,
    parameter int DATA_WIDTH        = 32,
    parameter int PARTICLE_ID_WIDTH = 7,
    parameter int FORCE_DATA_WIDTH  = 3 * DATA_WIDTH + PARTICLE_ID_WIDTH,
    parameter int PACKET_WIDTH      = FORCE_DATA_WIDTH + $clog2(NUM_CELLS),
    parameter int NUM_SRC           = 4,
    parameter int COUNT_WIDTH       = 16
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   phase_start,
    input  logic [NUM_SRC-1:0][PACKET_WIDTH-1:0]   src_pkt,
    input  logic [NUM_SRC-1:0]                     src_valid,
    input  logic [NUM_SRC-1:0]                     src_done,
    output logic [NUM_SRC-1:0]                     src_ready,
    output logic [PACKET_WIDTH-1:0]                pkt_out,
    output logic                                   pkt_valid,
    input  logic                                   node_ready,
    output logic                                   inject_done,
    output logic [COUNT_WIDTH-1:0]                 pkt_count,
    output logic                                   busy
);

    localparam int PTR_W = $clog2(NUM_SRC);

    inj_state_t              state, state_nxt;
    logic [PTR_W-1:0]        rr_ptr;
    logic [PTR_W-1:0]        gnt_idx;
    logic [NUM_SRC-1:0]      gnt;
    logic                    arb_en;
    logic                    out_free;
    logic                    src_xfer;
    logic                    node_xfer;
    logic                    all_done;
    logic                    phase_go;
    logic [PACKET_WIDTH-1:0] out_pkt_p1;
    logic                    out_vld_p1;
    logic [COUNT_WIDTH-1:0]  cnt;

    function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign out_free  = ~out_vld_p1 | node_ready;
    assign node_xfer = out_vld_p1 & node_ready;
    assign src_xfer  = |(src_valid & gnt);
    assign all_done  = &(src_done & ~src_valid);
    assign phase_go  = phase_start & ((state == IDLE) | (state == DONE));

    rr_arbiter #(
        .N(NUM_SRC)
    ) u_arb (
        .req    (src_valid),
        .en     (arb_en),
        .ptr    (rr_ptr),
        .gnt    (gnt),
        .gnt_idx(gnt_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (phase_start) state_nxt = RUN;
            RUN:     if (all_done) state_nxt = DRAIN;
            DRAIN:   if (!out_vld_p1 || node_xfer) state_nxt = DONE;
            DONE:    if (phase_start) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        arb_en      = 1'b0;
        inject_done = 1'b0;
        busy        = 1'b0;
        case (state)
            RUN: begin
                arb_en = out_free;
                busy   = 1'b1;
            end
            DRAIN:   busy = 1'b1;
            DONE:    inject_done = 1'b1;
            default: ;
        endcase
    end

    // p0 -> p1: granted source packet captured into the output register
    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld_p1 <= 1'b0;
            out_pkt_p1 <= '0;
            rr_ptr     <= '0;
        end else if (src_xfer) begin
            out_vld_p1 <= 1'b1;
            out_pkt_p1 <= src_pkt[gnt_idx];
            rr_ptr     <= (gnt_idx == PTR_W'(NUM_SRC - 1)) ? '0 : gnt_idx + 1'b1;
        end else if (node_xfer) begin
            out_vld_p1 <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)            cnt <= '0;
        else if (phase_go)  cnt <= '0;
        else if (node_xfer) cnt <= sat_inc(cnt);
    end

    assign src_ready = gnt;
    assign pkt_out   = out_pkt_p1;
    assign pkt_valid = out_vld_p1;
    assign pkt_count = cnt;

endmodule

// File: tb/tb_ring_inject_arbiter.sv
// Directed bench for ring_inject_arbiter with a per-cycle behavioural model and packet scoreboard.
module tb_ring_inject_arbiter;

    localparam int NUM_SRC = 4;
    localparam int CW      = 16;
    localparam int PW      = 109;
    localparam int S_IDLE = 0, S_RUN = 1, S_DRAIN = 2, S_DONE = 3;

    logic                          clk = 1'b0;
    logic                          rst = 1'b1;
    logic                          phase_start = 1'b0;
    logic [NUM_SRC-1:0][PW-1:0]    src_pkt = '0;
    logic [NUM_SRC-1:0]            src_valid = '0;
    logic [NUM_SRC-1:0]            src_done = '0;
    logic [NUM_SRC-1:0]            src_ready;
    logic [PW-1:0]                 pkt_out;
    logic                          pkt_valid;
    logic                          node_ready = 1'b1;
    logic                          inject_done;
    logic [CW-1:0]                 pkt_count;
    logic                          busy;

    always #5 clk = ~clk;

    ring_inject_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .phase_start(phase_start),
        .src_pkt    (src_pkt),
        .src_valid  (src_valid),
        .src_done   (src_done),
        .src_ready  (src_ready),
        .pkt_out    (pkt_out),
        .pkt_valid  (pkt_valid),
        .node_ready (node_ready),
        .inject_done(inject_done),
        .pkt_count  (pkt_count),
        .busy       (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [PW-1:0] mk(input int s, input int n);
        md_ring_pkg::packet_t p;
        p.dest_id = 6'(n);
        p.payload = 103'(s * 4096 + n + 1);
        return p;
    endfunction

    // Source drivers: each source presents the head of its queue and pops on acceptance.
    logic [PW-1:0]      src_q [NUM_SRC][$];
    int                 grant_log [$];
    logic [NUM_SRC-1:0] drv_x;

    always @(posedge clk) begin
        drv_x = src_valid & src_ready;
        #1;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (drv_x[i]) begin
                grant_log.push_back(i);
                if (src_q[i].size() != 0) void'(src_q[i].pop_front());
            end
        end
        for (int i = 0; i < NUM_SRC; i++) begin
            src_valid[i] = (src_q[i].size() != 0);
            src_pkt[i]   = src_valid[i] ? src_q[i][0] : '0;
        end
    end

    // Behavioural model: phase state, held-packet queue, counter and rotating priority.
    int            m_state = S_IDLE;
    int            m_ptr   = 0;
    bit            m_vld   = 1'b0;
    bit            known   = 1'b0;
    logic [CW-1:0] m_cnt   = '0;
    logic [PW-1:0] exp_q [$];

    always @(negedge clk) begin
        int                 g;
        int                 idx;
        bit                 en, nx, ad, was_vld;
        logic [NUM_SRC-1:0] er;
        g  = -1;
        er = '0;
        en = (m_state == S_RUN) && (!m_vld || node_ready);
        if (en) begin
            for (int k = 0; k < NUM_SRC; k++) begin
                idx = (m_ptr + k) % NUM_SRC;
                if (g < 0 && src_valid[idx]) g = idx;
            end
        end
        if (g >= 0) er[g] = 1'b1;
        if (known) begin
            check("src_ready", 128'(src_ready), 128'(er));
            check("pkt_valid", 128'(pkt_valid), 128'(m_vld));
            if (m_vld && exp_q.size() != 0) check("pkt_out", 128'(pkt_out), 128'(exp_q[0]));
            check("inject_done", 128'(inject_done), 128'(m_state == S_DONE));
            check("busy", 128'(busy), 128'(m_state == S_RUN || m_state == S_DRAIN));
            check("pkt_count", 128'(pkt_count), 128'(m_cnt));
        end
        if (rst) begin
            known   = 1'b1;
            m_state = S_IDLE;
            m_ptr   = 0;
            m_vld   = 1'b0;
            m_cnt   = '0;
            exp_q.delete();
        end else if (known) begin
            was_vld = m_vld;
            nx      = m_vld && node_ready;
            ad      = &(src_done & ~src_valid);
            if (nx) begin
                void'(exp_q.pop_front());
                m_vld = 1'b0;
                if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 1'b1;
            end
            if (g >= 0) begin
                exp_q.push_back(src_pkt[g]);
                m_vld = 1'b1;
                m_ptr = (g + 1) % NUM_SRC;
            end
            case (m_state)
                S_IDLE:  if (phase_start) begin m_state = S_RUN; m_cnt = '0; end
                S_RUN:   if (ad) m_state = S_DRAIN;
                S_DRAIN: if (!was_vld || nx) m_state = S_DONE;
                default: if (phase_start) begin m_state = S_RUN; m_cnt = '0; end
            endcase
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input int s, input int n);
        src_q[s].push_back(mk(s, n));
    endtask

    task automatic wait_grants(input int n);
        int k = 0;
        while (grant_log.size() < n && k < 200) begin cyc(); k++; end
        check("grant_total", 128'(grant_log.size()), 128'(n));
    endtask

    task automatic wait_drain();
        int k = 0;
        while ((pkt_valid !== 1'b0 || src_valid !== '0) && k < 200) begin cyc(); k++; end
        check("drain_reached", 128'(pkt_valid === 1'b0 && src_valid === '0), 128'(1));
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) cyc();
        rst = 1'b0;
        check("rst_pkt_valid", 128'(pkt_valid), 128'(0));
        check("rst_pkt_count", 128'(pkt_count), 128'(0));
        check("rst_inject_done", 128'(inject_done), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));

        // Fairness: every source always valid
        for (int n = 0; n < 2; n++)
            for (int s = 0; s < NUM_SRC; s++) push(s, n);
        phase_start = 1'b1;
        cyc();
        phase_start = 1'b0;
        wait_grants(8);
        wait_drain();
        for (int i = 0; i < 8; i++) check("fair_order", 128'(grant_log[i]), 128'(i % 4));
        check("fair_count", 128'(pkt_count), 128'(8));

        // Sparse: advance pointer to 1, then src2/src0, then src1/src3
        push(0, 10);
        wait_grants(9);
        wait_drain();
        push(2, 11);
        push(0, 12);
        wait_grants(11);
        check("sparse_first", 128'(grant_log[9]), 128'(2));
        check("sparse_second", 128'(grant_log[10]), 128'(0));
        push(1, 13);
        push(3, 14);
        wait_grants(13);
        check("sparse_ptr1", 128'(grant_log[11]), 128'(1));
        check("sparse_ptr3", 128'(grant_log[12]), 128'(3));
        wait_drain();
        check("sparse_count", 128'(pkt_count), 128'(13));

        // Backpressure
        node_ready = 1'b0;
        push(0, 20);
        push(0, 21);
        push(0, 22);
        wait_grants(14);
        repeat (5) begin
            cyc();
            check("bp_valid", 128'(pkt_valid), 128'(1));
            check("bp_hold", 128'(pkt_out), 128'(mk(0, 20)));
            check("bp_ready", 128'(src_ready), 128'(0));
        end
        check("bp_no_extra", 128'(grant_log.size()), 128'(14));
        node_ready = 1'b1;
        wait_drain();
        check("bp_grants", 128'(grant_log.size()), 128'(16));
        check("bp_count", 128'(pkt_count), 128'(16));

        // Completion with the final packet held
        node_ready = 1'b0;
        push(3, 30);
        wait_grants(17);
        src_done = '1;
        cyc();
        check("drain_busy", 128'(busy), 128'(1));
        check("drain_not_done", 128'(inject_done), 128'(0));
        cyc();
        check("drain_hold_busy", 128'(busy), 128'(1));
        check("drain_hold_valid", 128'(pkt_valid), 128'(1));
        check("drain_hold_not_done", 128'(inject_done), 128'(0));
        node_ready = 1'b1;
        cyc();
        check("done_flag", 128'(inject_done), 128'(1));
        check("done_busy", 128'(busy), 128'(0));
        check("done_count", 128'(pkt_count), 128'(17));
        check("done_valid", 128'(pkt_valid), 128'(0));

        // Re-arm, then a phase_start inside RUN must not clear the count
        src_done = '0;
        phase_start = 1'b1;
        cyc();
        phase_start = 1'b0;
        check("rearm_busy", 128'(busy), 128'(1));
        check("rearm_done", 128'(inject_done), 128'(0));
        check("rearm_count", 128'(pkt_count), 128'(0));
        push(1, 40);
        push(1, 41);
        wait_grants(19);
        wait_drain();
        check("rearm_sent", 128'(pkt_count), 128'(2));
        phase_start = 1'b1;
        cyc();
        phase_start = 1'b0;
        check("run_start_count", 128'(pkt_count), 128'(2));
        check("run_start_busy", 128'(busy), 128'(1));
        push(1, 42);
        wait_grants(20);
        wait_drain();
        check("run_start_more", 128'(pkt_count), 128'(3));

        // Reset mid-phase with a packet held
        node_ready = 1'b0;
        push(2, 50);
        push(2, 51);
        wait_grants(21);
        src_q[2].delete();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("mid_rst_valid", 128'(pkt_valid), 128'(0));
        check("mid_rst_count", 128'(pkt_count), 128'(0));
        check("mid_rst_done", 128'(inject_done), 128'(0));
        check("mid_rst_busy", 128'(busy), 128'(0));
        check("mid_rst_pkt", 128'(pkt_out), 128'(0));
        check("mid_rst_ready", 128'(src_ready), 128'(0));
        node_ready = 1'b1;
        repeat (3) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ring_inject_arbiter.md
Name: ring_inject_arbiter

Overview:
Per-cell scheduler that shares one ring node's PE injection port among NUM_SRC force-producing sources, such as the cell's force pipelines. It uses round-robin arbitration into a single-entry output register. Handshakes with the node use the node's valid/ready pair. A phase FSM gates injection to the force-evaluation phase and reports when all of the cell's packets for that phase have left the cell.

Parameters:
NUM_CELLS, 64, ring size; sets the dest_id width.
DATA_WIDTH, 32, width of one force component.
PARTICLE_ID_WIDTH, 7, particle id width.
FORCE_DATA_WIDTH, 3*DATA_WIDTH+PARTICLE_ID_WIDTH, payload width.
PACKET_WIDTH, FORCE_DATA_WIDTH+$clog2(NUM_CELLS), {dest_id, payload}.
NUM_SRC, 4, number of requesting sources (>=2).
COUNT_WIDTH, 16, width of the injected-packet counter.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
phase_start  in  1  one-cycle pulse; begins an injection phase
src_pkt  in  [NUM_SRC][PACKET_WIDTH]  per-source packet
src_valid  in  NUM_SRC  per-source packet valid
src_done  in  NUM_SRC  level; source has no further packets this phase
src_ready  out  NUM_SRC  one-hot grant/accept
pkt_out  out  PACKET_WIDTH  to the ring node's pe_pkt_in
pkt_valid  out  1  to the ring node's pe_pkt_valid
node_ready  in  1  from the ring node's pe_ready
inject_done  out  1  level; phase complete
pkt_count  out  COUNT_WIDTH  packets handed to the node this phase
busy  out  1  FSM is in RUN or DRAIN

Behaviour:
- Reset. All of the following clear in the cycle after rst is sampled high: FSM to IDLE, pkt_valid=0, pkt_out=0, src_ready=0, inject_done=0, pkt_count=0, busy=0, rr_ptr=0. A reset mid-phase discards any held packet.
- Transfer rules.
  - Source i transfers when src_valid[i] && src_ready[i].
  - The node transfers when pkt_valid && node_ready.
  - Sources must hold src_pkt stable while valid and not ready.
- Output register.
  - out_free = ~pkt_valid | node_ready.
  - src_ready is nonzero only in RUN with out_free=1.
  - When out_free is high and no source transfers, pkt_valid drops to 0 after a node transfer.
- Latency and throughput.
  - Latency is 1 cycle: a packet accepted at edge N appears on pkt_out/pkt_valid after edge N.
  - Throughput is 1 packet/cycle while node_ready=1.
  - pkt_out holds stable while pkt_valid=1 and node_ready=0.
- Arbitration.
  - Grant goes to the first i with src_valid[i] high, scanning rr_ptr, rr_ptr+1, ... mod NUM_SRC.
  - After a transfer from source g, rr_ptr becomes (g+1) mod NUM_SRC.
  - With no transfer, rr_ptr holds.
  - src_ready is combinational from src_valid, rr_ptr, state and out_free. At most one bit is high.
- Completion term: all_done = &(src_done & ~src_valid). A source raising done while still valid does not count until its valid drops.
- FSM states and transitions:
  - IDLE: no grants. phase_start -> RUN, and pkt_count clears to 0.
  - RUN: arbitrate. all_done -> DRAIN. A phase_start pulse here is ignored.
  - DRAIN: no grants. Transitions once pkt_valid=0, or when a node transfer occurs this cycle -> DONE.
  - DONE: inject_done=1 and pkt_count holds its final value. phase_start -> RUN, and in that same cycle pkt_count clears and inject_done falls.
- pkt_count increments on each node transfer and saturates at 2^COUNT_WIDTH-1.
- Simultaneous events:
  - A source transfer and a node transfer in the same cycle: the register reloads and pkt_valid stays 1.
  - all_done rising in the same cycle as a final source transfer: that packet is accepted, then the FSM enters DRAIN.
- busy = (state==RUN) | (state==DRAIN).

Decomposition:
- Shared package (md_ring_pkg):
  - typedef packet_t as the {dest_id, payload} struct, built from NUM_CELLS, DATA_WIDTH and PARTICLE_ID_WIDTH;
  - function node_id_width();
  - enum inj_state_t {IDLE, RUN, DRAIN, DONE}.
- Sub-module rr_arbiter (parameter N). Inputs req, en, ptr. Outputs one-hot gnt, and gnt_idx for the rr_ptr update. It is reused elsewhere for other shared ports.

Test Plan:
- Reset mid-phase: 2 packets injected, then rst pulsed -> next cycle pkt_valid=0, pkt_count=0, inject_done=0, state IDLE.
- Fairness: NUM_SRC=4, all valid constantly, node_ready=1, 8 packets -> grant order 0,1,2,3,0,1,2,3; pkt_count=8.
- Backpressure: node_ready=0 for 5 cycles with src0 valid -> pkt_out stable; src_ready=0 after the first accept; node_ready=1 -> 1 transfer per cycle resumes with no loss or duplication; scoreboard matches.
- Sparse requests: only src2 and src0 valid, rr_ptr=1 -> src2 granted first, then src0, then rr_ptr=1.
- Completion: all src_done high while the final packet is held with node_ready=0 -> state DRAIN, inject_done=0; node_ready=1 -> DONE next cycle, inject_done=1, pkt_count equals the total sent.
- Re-arm: phase_start in DONE -> RUN with pkt_count=0 and inject_done=0. phase_start during RUN has no effect.
